// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources, with a tx_done watchdog.
// Optional burst lock is enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [IDX_W-1:0]     owner,
    output logic                 active,
    output logic                 err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, WAIT_DONE} state_t;

    state_t               state, state_d;
    logic [IDX_W-1:0]     rr, rr_d, owner_d;
    logic [NUM_REQ-1:0]   grant_d;
    logic                 tx_start_d, err_d;
    logic [7:0]           tx_data_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_vld;

`ifdef UART_TX_ARB_LOCK_EN
    logic                 last_q, last_d;
`else
    logic                 unused_req_last;
    assign unused_req_last = ^req_last;
`endif

    // Scan downward so the requester closest after rr is the last one written and wins.
    always_comb begin
        int s;
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            s = int'(rr) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            if (req[s]) begin
                win_idx = IDX_W'(s);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state;
        rr_d       = rr;
        owner_d    = owner;
        grant_d    = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data;
        err_d      = 1'b0;
        cnt_d      = cnt;
`ifdef UART_TX_ARB_LOCK_EN
        last_d     = last_q;
`endif
        case (state)
            IDLE: begin
                if (win_vld && !tx_busy) begin
                    grant_d    = NUM_REQ'(1) << win_idx;
                    tx_start_d = 1'b1;
                    tx_data_d  = req_data[win_idx*8 +: 8];
                    owner_d    = win_idx;
                    cnt_d      = '0;
                    state_d    = WAIT_DONE;
`ifdef UART_TX_ARB_LOCK_EN
                    last_d     = req_last[win_idx];
`endif
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    rr_d    = owner;
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef UART_TX_ARB_LOCK_EN
                    // Mid-burst: hand the transmitter straight back to the owner.
                    if (!last_q && req[owner]) begin
                        grant_d    = NUM_REQ'(1) << owner;
                        tx_start_d = 1'b1;
                        tx_data_d  = req_data[owner*8 +: 8];
                        last_d     = req_last[owner];
                        state_d    = WAIT_DONE;
                    end
`endif
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    rr_d    = owner;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr          <= IDX_W'(NUM_REQ - 1);
            owner       <= '0;
            grant       <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            err_timeout <= 1'b0;
            cnt         <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            last_q      <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            rr          <= rr_d;
            owner       <= owner_d;
            grant       <= grant_d;
            tx_start    <= tx_start_d;
            tx_data     <= tx_data_d;
            err_timeout <= err_d;
            cnt         <= cnt_d;
`ifdef UART_TX_ARB_LOCK_EN
            last_q      <= last_d;
`endif
        end
    end

    assign active = (state == WAIT_DONE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, short watchdog).
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int T = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [1:0]     owner;
    logic           active;
    logic           err_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .grant(grant), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .tx_done(tx_done), .owner(owner), .active(active), .err_timeout(err_timeout)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_last = '0; tx_busy = 1'b0; tx_done = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    logic [7:0] bytes [4];
    logic [3:0] lk_grant [4];
    int         lk_gap [3];

    initial begin
        bytes    = '{8'hA5, 8'h22, 8'h33, 8'h44};
        req_data = {8'h44, 8'h33, 8'h22, 8'hA5};

        // reset state
        step(2);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_err", 32'(err_timeout), 32'h0);

        // single requester
        rst = 1'b0;
        req = 4'b0001;
        step();
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_start", 32'(tx_start), 32'h1);
        chk("single_data", 32'(tx_data), 32'hA5);
        chk("single_active", 32'(active), 32'h1);
        req = '0;
        step();
        chk("single_grant_pulse", 32'(grant), 32'h0);
        chk("single_start_pulse", 32'(tx_start), 32'h0);
        step(3);
        chk("single_data_hold", 32'(tx_data), 32'hA5);
        pulse_done();
        chk("single_idle", 32'(active), 32'h0);
        step();
        chk("single_no_regrant", 32'(grant), 32'h0);

        // round-robin order 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("rr_grant", 32'(grant), 32'(1 << (i % 4)));
            chk("rr_owner", 32'(owner), 32'(i % 4));
            chk("rr_data", 32'(tx_data), 32'(bytes[i % 4]));
            if (i == 4) req = '0;
            step(19);
            pulse_done();
            chk("rr_idle_gap", 32'(active), 32'h0);
            if (i < 4) step();
        end

        // busy blocking
        do_reset();
        tx_busy = 1'b1;
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("busy_blocked", 32'(grant), 32'h0);
        end
        tx_busy = 1'b0;
        step();
        chk("busy_release_grant", 32'(grant), 32'h4);
        chk("busy_release_owner", 32'(owner), 32'h2);
        req = '0;
        step(2);
        pulse_done();

        // watchdog expiry, then requester 1 served
        do_reset();
        req = 4'b0011;
        step();
        chk("wd_grant0", 32'(grant), 32'h1);
        step(T - 1);
        chk("wd_not_yet", 32'(err_timeout), 32'h0);
        chk("wd_still_active", 32'(active), 32'h1);
        step();
        chk("wd_err", 32'(err_timeout), 32'h1);
        chk("wd_inactive", 32'(active), 32'h0);
        step();
        chk("wd_err_pulse", 32'(err_timeout), 32'h0);
        chk("wd_next_grant", 32'(grant), 32'h2);
        chk("wd_next_owner", 32'(owner), 32'h1);
        req = '0;
        step();
        pulse_done();

        // tx_done on the final count beats the watchdog
        do_reset();
        req = 4'b0001;
        step();
        req = '0;
        step(T - 1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("wd_tie_no_err", 32'(err_timeout), 32'h0);
        chk("wd_tie_idle", 32'(active), 32'h0);
        step();
        chk("wd_tie_no_err_late", 32'(err_timeout), 32'h0);

        // tx_done in IDLE is ignored; withdrawn request never granted
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("idle_done_active", 32'(active), 32'h0);
        chk("idle_done_grant", 32'(grant), 32'h0);
        tx_busy = 1'b1;
        req = 4'b0010;
        step(2);
        req = '0;
        tx_busy = 1'b0;
        step(2);
        chk("withdrawn_grant", 32'(grant), 32'h0);
        chk("withdrawn_active", 32'(active), 32'h0);

        // burst: req0 offers bytes with last=0,0,1 while req1 pends
`ifdef UART_TX_ARB_LOCK_EN
        lk_grant = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
        lk_gap   = '{0, 0, 1};
`else
        lk_grant = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        lk_gap   = '{1, 1, 1};
`endif
        do_reset();
        req = 4'b0011;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("burst_grant", 32'(grant), 32'(lk_grant[i]));
            chk("burst_start", 32'(tx_start), 32'h1);
            if (i == 1) req_last[0] = 1'b1;
            if (i == 2) req[0] = 1'b0;
            if (i == 3) req = '0;
            step(3);
            pulse_done();
            if (i < 3 && lk_gap[i] != 0) begin
                chk("burst_idle_gap", 32'(grant), 32'h0);
                step();
            end
        end
        req_last = '0;

        // asynchronous reset in WAIT_DONE
        do_reset();
        req = 4'b0001;
        step();
        #3 rst = 1'b1;
        #1;
        chk("arst_active", 32'(active), 32'h0);
        chk("arst_start", 32'(tx_start), 32'h0);
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_data", 32'(tx_data), 32'h0);
        step();
        rst = 1'b0;
        req = 4'b1111;
        step();
        chk("arst_first_grant", 32'(grant), 32'h1);
        req = '0;
        step();
        pulse_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
